// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller
// Frame-synchronous shadow update: new data only reaches the display at the digit 3 -> 0 wrap.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] data,
  input  logic        update,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  ane,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int PW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PW-1:0] DRIVE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t         state, state_n;
  logic [PW-1:0]  presc, presc_n;
  logic [1:0]     digit_n;
  logic [15:0]    shadow, shadow_n, pend, pend_n;
  logic           pend_flag, pend_flag_n;
  logic           boundary;
  logic [3:0]     nib;
  logic [3:0]     ane_n;
  logic [6:0]     seg_n;
  logic           dp_n, fd_n;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    presc_n     = presc;
    digit_n     = digit_sel;
    shadow_n    = shadow;
    pend_n      = pend;
    pend_flag_n = pend_flag;
    boundary    = (state == DRIVE) && (presc == DRIVE_LAST) && (digit_sel == 2'd3) && en;

    case (state)
      IDLE: begin
        if (en) begin
          state_n = BLANK;
          presc_n = '0;
        end
      end
      BLANK: begin
        if (presc == BLANK_LAST) begin
          state_n = DRIVE;
          presc_n = '0;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      DRIVE: begin
        if (presc == DRIVE_LAST) begin
          state_n = BLANK;
          presc_n = '0;
          digit_n = digit_sel + 2'd1;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (!en) begin
      state_n = IDLE;
      presc_n = '0;
      digit_n = 2'd0;
    end

    // Shadow only moves at the frame wrap (or while dark) so a frame never mixes old and new digits.
    if (state == IDLE) begin
      if (update) begin
        shadow_n    = data;
        pend_n      = data;
        pend_flag_n = 1'b0;
      end
    end else if (boundary) begin
      if (update) begin
        shadow_n = data;
      end else if (pend_flag) begin
        shadow_n = pend;
      end
      pend_flag_n = 1'b0;
    end else if (update) begin
      pend_n      = data;
      pend_flag_n = 1'b1;
    end

    // Outputs are computed from the next state so the registered outputs line up with it.
    nib   = 4'(shadow_n >> {digit_n, 2'b00});
    ane_n = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (state_n != IDLE) begin
      seg_n = hex_decode(nib);
      dp_n  = ~dp_mask[digit_n];
    end
    if ((state_n == DRIVE) && !blank_mask[digit_n]) begin
      ane_n = ~(4'b0001 << digit_n);
    end
    fd_n = (state_n == DRIVE) && (presc_n == DRIVE_LAST) && (digit_n == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      digit_sel  <= 2'd0;
      shadow     <= '0;
      pend       <= '0;
      pend_flag  <= 1'b0;
      ane        <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      digit_sel  <= digit_n;
      shadow     <= shadow_n;
      pend       <= pend_n;
      pend_flag  <= pend_flag_n;
      ane        <= ane_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized bench with a frame-position reference model
// The model tracks cycles since scan start and derives digit/phase arithmetically.
module tb_display_scan_ctrl;

  localparam int R     = 4;
  localparam int B     = 2;
  localparam int SLOT  = R + B;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  localparam logic [3:0] EXP_ANE [24] = '{
    4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
    4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
    4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
    4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] data = '0;
  logic        update = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  ane;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  bit          m_active = 0;
  int          m_t = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend = '0;
  bit          m_pflag = 0;
  logic [3:0]  e_ane = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic [1:0]  e_dsel = 2'd0;
  logic        e_fd = 1'b0;

  display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .update(update),
    .blank_mask(blank_mask), .dp_mask(dp_mask),
    .ane(ane), .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done));

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int dig, ph;
    logic [3:0] nib;
    if (rst) begin
      m_active = 0; m_t = 0; m_shadow = '0; m_pend = '0; m_pflag = 0;
    end else begin
      if (!m_active) begin
        if (update) begin m_shadow = data; m_pend = data; m_pflag = 0; end
      end else if (en && (m_t % FRAME) == FRAME - 1) begin
        if (update) m_shadow = data;
        else if (m_pflag) m_shadow = m_pend;
        m_pflag = 0;
      end else if (update) begin
        m_pend = data; m_pflag = 1;
      end
      if (!en) begin m_active = 0; m_t = 0; end
      else if (!m_active) begin m_active = 1; m_t = 0; end
      else m_t++;
    end
    if (!m_active) begin
      e_ane = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_dsel = 2'd0; e_fd = 1'b0;
    end else begin
      dig    = (m_t / SLOT) % 4;
      ph     = m_t % SLOT;
      nib    = 4'((m_shadow >> (4 * dig)) & 16'hF);
      e_seg  = SEG_TAB[nib];
      e_dp   = ~dp_mask[dig];
      e_ane  = (ph < B || blank_mask[dig]) ? 4'hF : ~(4'b0001 << dig);
      e_dsel = 2'(dig);
      e_fd   = ((m_t % FRAME) == FRAME - 1);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("ane", ane, e_ane);
      check("seg", seg, e_seg);
      check("dp", dp, e_dp);
      check("digit_sel", digit_sel, e_dsel);
      check("frame_done", frame_done, e_fd);
    end
  end

  task automatic wait_fd();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1; break; end
    end
    if (!ok) check("frame_done_timeout", 0, 1);
  endtask

  initial begin
    int period, lit, dpc;
    bit ok;
    repeat (3) @(negedge clk);
    check("rst_ane", ane, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_dsel", digit_sel, 2'd0);
    check("rst_fd", frame_done, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    update = 1'b1; data = 16'h1234; en = 1'b1;
    @(negedge clk);
    update = 1'b0;
    check("first_seg_4", seg, 7'b0011001);
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("ane_seq_%0d", i), ane, EXP_ANE[i]);
    end
    check("fd_first_frame", frame_done, 1'b1);
    period = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (frame_done) begin period = i; break; end
    end
    check("frame_period", period, 24);

    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (digit_sel == 2'd1) begin ok = 1; break; end
    end
    check("reach_digit1", ok, 1);
    update = 1'b1; data = 16'hABCD;
    @(negedge clk);
    update = 1'b0;
    wait_fd();
    @(negedge clk);
    check("new_frame_seg_d", seg, 7'b0100001);

    repeat (3) @(negedge clk);
    update = 1'b1; data = 16'h1111;
    @(negedge clk);
    update = 1'b0;
    repeat (5) @(negedge clk);
    update = 1'b1; data = 16'h2222;
    @(negedge clk);
    update = 1'b0;
    wait_fd();
    @(negedge clk);
    check("last_update_wins", seg, 7'b0100100);

    wait_fd();
    update = 1'b1; data = 16'h5555;
    @(negedge clk);
    update = 1'b0;
    check("boundary_pending_clear", dut.pend_flag, 1'b0);
    check("boundary_seg_5", seg, 7'b0010010);

    blank_mask = 4'b0100; dp_mask = 4'b0001;
    wait_fd();
    lit = 0; dpc = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (ane != 4'hF) lit++;
      if (dp == 1'b0) dpc++;
    end
    check("masked_lit_cycles", lit, 12);
    check("dp_low_cycles", dpc, 6);
    check("masked_period", frame_done, 1'b1);
    blank_mask = '0; dp_mask = '0;

    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ane != 4'hF) begin ok = 1; break; end
    end
    check("reach_drive", ok, 1);
    en = 1'b0;
    @(negedge clk);
    check("en_off_ane", ane, 4'hF);
    check("en_off_seg", seg, 7'h7F);
    en = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ane", ane, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    check("async_rst_dsel", digit_sel, 2'd0);
    check("async_rst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      update = ($urandom_range(0, 15) == 0);
      data   = 16'($urandom);
      if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom);
      en = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
